// File: rtl/clk_div_extend.sv
// Clock-pattern generator: divided clock, phase-lagged copy, faster divided clock and sticky lock flag.
// Every output is a flop in the sys_clk domain, usable as an enable or forwarded to a pin.
module clk_div_extend #(
  parameter int unsigned DIV_A       = 9,
  parameter int unsigned PHASE_A     = 3,
  parameter int unsigned DIV_B       = 3,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic clk_33,
  output logic clk_33_deg,
  output logic clk_100m,
  output logic locked
);

  if (DIV_A < 2 || DIV_A > 255) begin : gBadDivA
    $error("clk_div_extend: DIV_A must be in 2..255");
  end
  if (DIV_B < 2 || DIV_B > 255) begin : gBadDivB
    $error("clk_div_extend: DIV_B must be in 2..255");
  end
  if (PHASE_A >= DIV_A) begin : gBadPhase
    $error("clk_div_extend: PHASE_A must be below DIV_A");
  end
  if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : gBadLock
    $error("clk_div_extend: LOCK_CYCLES must be in 1..65535");
  end

  localparam logic [7:0]  A_LAST    = 8'(DIV_A - 1);
  localparam logic [7:0]  A_HALF    = 8'(DIV_A / 2);
  localparam logic [7:0]  B_LAST    = 8'(DIV_B - 1);
  localparam logic [7:0]  B_HALF    = 8'(DIV_B / 2);
  // Starting the lag counter this far "behind" makes it reach zero exactly PHASE_A edges late.
  localparam logic [7:0]  P_INIT    = 8'((DIV_A - PHASE_A) % DIV_A);
  localparam logic [15:0] LOCK_SAT  = 16'(LOCK_CYCLES);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);

  logic [7:0]  cntA_q, cntA_d;
  logic [7:0]  cntP_q, cntP_d;
  logic [7:0]  cntB_q, cntB_d;
  logic [15:0] lockCnt_q, lockCnt_d;
  logic        clk33_q, clk33_d;
  logic        clk33Deg_q, clk33Deg_d;
  logic        clk100_q, clk100_d;
  logic        locked_q, locked_d;

  // Waveform levels decode the pre-increment counter values, giving one register stage of latency.
  always_comb begin
    cntA_d     = (cntA_q == A_LAST) ? 8'd0 : cntA_q + 8'd1;
    cntP_d     = (cntP_q == A_LAST) ? 8'd0 : cntP_q + 8'd1;
    cntB_d     = (cntB_q == B_LAST) ? 8'd0 : cntB_q + 8'd1;
    lockCnt_d  = (lockCnt_q == LOCK_SAT) ? lockCnt_q : lockCnt_q + 16'd1;
    clk33_d    = (cntA_q < A_HALF);
    clk33Deg_d = (cntP_q < A_HALF);
    clk100_d   = (cntB_q < B_HALF);
    locked_d   = (lockCnt_q == LOCK_LAST) | locked_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cntA_q     <= 8'd0;
      cntP_q     <= P_INIT;
      cntB_q     <= 8'd0;
      lockCnt_q  <= 16'd0;
      clk33_q    <= 1'b0;
      clk33Deg_q <= 1'b0;
      clk100_q   <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      cntA_q     <= cntA_d;
      cntP_q     <= cntP_d;
      cntB_q     <= cntB_d;
      lockCnt_q  <= lockCnt_d;
      clk33_q    <= clk33_d;
      clk33Deg_q <= clk33Deg_d;
      clk100_q   <= clk100_d;
      locked_q   <= locked_d;
    end
  end

  assign clk_33     = clk33_q;
  assign clk_33_deg = clk33Deg_q;
  assign clk_100m   = clk100_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_clk_div_extend.sv
// Bench for clk_div_extend: four parameterisations driven by a shared reset stimulus,
// each compared every cycle against an edge-count-based reference model.
module tb_clk_div_extend;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [3:0] c33, c33d, c100, lck;

  int checks   = 0;
  int failures = 0;
  int edgeN    = 0;

  int divA[4]  = '{9, 9, 2, 5};
  int phA[4]   = '{3, 0, 1, 4};
  int divB[4]  = '{3, 2, 4, 7};
  int lockC[4] = '{16, 3, 1, 5};

  always #5 sys_clk = ~sys_clk;

  clk_div_extend #(.DIV_A(9), .PHASE_A(3), .DIV_B(3), .LOCK_CYCLES(16)) u0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .clk_33(c33[0]), .clk_33_deg(c33d[0]),
    .clk_100m(c100[0]), .locked(lck[0]));
  clk_div_extend #(.DIV_A(9), .PHASE_A(0), .DIV_B(2), .LOCK_CYCLES(3)) u1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .clk_33(c33[1]), .clk_33_deg(c33d[1]),
    .clk_100m(c100[1]), .locked(lck[1]));
  clk_div_extend #(.DIV_A(2), .PHASE_A(1), .DIV_B(4), .LOCK_CYCLES(1)) u2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .clk_33(c33[2]), .clk_33_deg(c33d[2]),
    .clk_100m(c100[2]), .locked(lck[2]));
  clk_div_extend #(.DIV_A(5), .PHASE_A(4), .DIV_B(7), .LOCK_CYCLES(5)) u3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .clk_33(c33[3]), .clk_33_deg(c33d[3]),
    .clk_100m(c100[3]), .locked(lck[3]));

  // Level of a square wave high for floor(div/2) of every div edges, started `lag` edges late,
  // as seen n edges after reset release (n = 0 means still in reset).
  function automatic logic expWave(input int n, input int div, input int lag);
    if (n == 0) return 1'b0;
    return ((n - 1 + div - lag) % div) < (div / 2);
  endfunction

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s at edge %0d: got %0d expected %0d", tag, edgeN, got, exp);
    end
  endtask

  task automatic checkAll();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("u%0d.clk_33", i), int'(c33[i]), int'(expWave(edgeN, divA[i], 0)));
      checkOutput($sformatf("u%0d.clk_33_deg", i), int'(c33d[i]),
                  int'(expWave(edgeN, divA[i], phA[i])));
      checkOutput($sformatf("u%0d.clk_100m", i), int'(c100[i]), int'(expWave(edgeN, divB[i], 0)));
      checkOutput($sformatf("u%0d.locked", i), int'(lck[i]), int'(edgeN >= lockC[i]));
    end
  endtask

  // Drive reset for one edge, advance the model's edge count, then sample on the falling edge.
  task automatic applyStimulus(input logic rst);
    sys_rst = rst;
    @(posedge sys_clk);
    edgeN = rst ? 0 : edgeN + 1;
    @(negedge sys_clk);
    checkAll();
  endtask

  initial begin
    int rises33;
    int rises100;
    logic prev33;
    logic prev100;

    $display("[TB] start");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1);

    rises33  = 0;
    rises100 = 0;
    prev33   = c33[0];
    prev100  = c100[0];
    for (int i = 0; i < 90; i++) begin
      applyStimulus(1'b0);
      if (c33[0] && !prev33) rises33++;
      if (c100[0] && !prev100) rises100++;
      prev33  = c33[0];
      prev100 = c100[0];
    end
    checkOutput("u0.rises33", rises33, 10);
    checkOutput("u0.rises100", rises100, 30);

    for (int i = 90; i < 1000; i++) applyStimulus(1'b0);
    checkOutput("u0.lockedAt1000", int'(lck[0]), 1);

    applyStimulus(1'b1);
    for (int i = 0; i < 36; i++) applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("midResetAllLow", int'({c33, c33d, c100, lck}), 0);
    for (int i = 0; i < 60; i++) applyStimulus(1'b0);

    for (int i = 0; i < 2000; i++) applyStimulus($urandom_range(0, 99) < 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
